// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   LDST_* : RISC-V funct3 load/store size encodings
//   lsu_state_t : access sequencing FSM states
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_formatter.sv
// Load data formatter: selects the byte/halfword lane of a memory word and
// sign- or zero-extends it according to the funct3 size.
//   i_rd      : full memory word
//   i_addr_lo : byte address bits [1:0]
//   i_size    : funct3 size; anything other than B/H/BU/HU returns the word
//   o_data    : formatted 32-bit result
// Halfwords use only i_addr_lo[1]; words ignore the address.
module lsu_load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd[7:0];
    unique case (i_addr_lo)
      2'd0: w_byte = i_rd[7:0];
      2'd1: w_byte = i_rd[15:8];
      2'd2: w_byte = i_rd[23:16];
      2'd3: w_byte = i_rd[31:24];
      default: w_byte = i_rd[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rd[31:16] : i_rd[15:0];
  end

  always_comb begin
    o_data = i_rd;
    case (i_size)
      LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LDST_BU: o_data = {24'h0, w_byte};
      LDST_H:  o_data = {{16{w_half[15]}}, w_half};
      LDST_HU: o_data = {16'h0, w_half};
      default: o_data = i_rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and a word-addressed data memory.
// Formats sub-word loads and performs read-modify-write for SB/SH since the
// memory only writes whole words. Stalls the core until each access is done.
//   clk, rst_n          : clock, async active-low reset
//   core_req_i/we/size  : request, store flag, funct3 size
//   core_addr_i/wd_i    : byte address, right-aligned store data
//   core_rd_o           : registered load data
//   core_stall_o        : core must hold its request
//   core_misalign_o     : one-cycle pulse on misaligned/illegal access
//   mem_we_o/a_o/wd_o   : memory write enable, word address, write data
//   mem_rd_i            : combinational memory read data
// Macro LSU_MISALIGN_CHECK_EN enables alignment and illegal-size checking;
// when undefined, H/W ignore low address bits and illegal sizes act as W.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [2:0]       core_size_i,
  input  logic [WIDTH-1:0] core_addr_i,
  input  logic [WIDTH-1:0] core_wd_i,
  output logic [WIDTH-1:0] core_rd_o,
  output logic             core_stall_o,
  output logic             core_misalign_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  lsu_state_t       r_state;
  lsu_state_t       w_state_next;
  logic [WIDTH-1:0] r_rd;
  logic [WIDTH-1:0] r_merge;
  logic             r_misalign;

  logic             w_err;
  logic [2:0]       w_size_eff;
  logic             w_accept;
  logic             w_sub_store;
  logic [WIDTH-1:0] w_fmt;
  logic [WIDTH-1:0] w_merge;
  logic [1:0]       w_lo;

  assign w_lo = core_addr_i[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_illegal;
  logic w_misalign;
  assign w_illegal  = (core_size_i == 3'b011) || (core_size_i[2:1] == 2'b11) ||
                      (core_we_i && core_size_i[2]);
  // H/HU share size[1:0]=01; W is the only legal 010 encoding.
  assign w_misalign = ((core_size_i[1:0] == 2'b01) && w_lo[0]) ||
                      ((core_size_i == LDST_W) && (w_lo != 2'b00));
  assign w_err      = w_illegal || w_misalign;
  assign w_size_eff = core_size_i;
`else
  assign w_err = 1'b0;
  // Unrecognised sizes collapse to a full-word access.
  always_comb begin
    w_size_eff = LDST_W;
    if (!core_we_i) begin
      if (core_size_i == LDST_B || core_size_i == LDST_H ||
          core_size_i == LDST_BU || core_size_i == LDST_HU) begin
        w_size_eff = core_size_i;
      end
    end else if (core_size_i == LDST_B || core_size_i == LDST_H) begin
      w_size_eff = core_size_i;
    end
  end
`endif

  assign w_accept    = (r_state == StIdle) && core_req_i;
  assign w_sub_store = core_we_i && ((w_size_eff == LDST_B) || (w_size_eff == LDST_H));

  lsu_load_formatter u_fmt (
    .i_rd      (mem_rd_i),
    .i_addr_lo (w_lo),
    .i_size    (w_size_eff),
    .o_data    (w_fmt)
  );

  // Sub-word store merge into the current memory word.
  always_comb begin
    w_merge = mem_rd_i;
    if (w_size_eff == LDST_B) begin
      unique case (w_lo)
        2'd0: w_merge[7:0]   = core_wd_i[7:0];
        2'd1: w_merge[15:8]  = core_wd_i[7:0];
        2'd2: w_merge[23:16] = core_wd_i[7:0];
        2'd3: w_merge[31:24] = core_wd_i[7:0];
        default: w_merge = mem_rd_i;
      endcase
    end else if (w_size_eff == LDST_H) begin
      if (w_lo[1]) w_merge[31:16] = core_wd_i[15:0];
      else         w_merge[15:0]  = core_wd_i[15:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_we_o     = 1'b0;
    mem_wd_o     = r_merge;
    case (r_state)
      StIdle: begin
        if (core_req_i) begin
          w_state_next = StDone;
          if (!w_err && core_we_i) begin
            if (w_sub_store) begin
              w_state_next = StWrite;
            end else begin
              mem_we_o = 1'b1;
              mem_wd_o = core_wd_i;
            end
          end
        end
      end
      // Completes even if the request has dropped.
      StWrite: begin
        mem_we_o     = 1'b1;
        w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rd       <= '0;
      r_merge    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_misalign <= w_accept && w_err;
      if (w_accept) begin
        if (w_err) begin
          r_rd <= '0;
        end else if (!core_we_i) begin
          r_rd <= w_fmt;
        end else if (w_sub_store) begin
          r_merge <= w_merge;
        end
      end
    end
  end

  assign core_rd_o       = r_rd;
  assign core_misalign_o = r_misalign;
  assign core_stall_o    = core_req_i && (r_state != StDone);
  assign mem_a_o         = {core_addr_i[WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed requests and
// pushes hand-computed expectations; a monitor pops and compares on each
// completion (request held with stall low). Includes a word-addressed memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'b000;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wd_i = 32'h0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misalign_o;
  logic        mem_we_o;
  logic [31:0] mem_a_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req_i      (core_req_i),
    .core_we_i       (core_we_i),
    .core_size_i     (core_size_i),
    .core_addr_i     (core_addr_i),
    .core_wd_i       (core_wd_i),
    .core_rd_o       (core_rd_o),
    .core_stall_o    (core_stall_o),
    .core_misalign_o (core_misalign_o),
    .mem_we_o        (mem_we_o),
    .mem_a_o         (mem_a_o),
    .mem_wd_o        (mem_wd_o),
    .mem_rd_i        (mem_rd_i)
  );

  // 16-word memory at 0x00..0x3F; other addresses read as 0.
  logic [31:0] mem [0:15];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'h0;

  assign mem_rd_i = (mem_a_o < 32'h40) ? mem[mem_a_o[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (mem_we_o && mem_a_o < 32'h40) mem[mem_a_o[5:2]] <= mem_wd_o;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        chk_rd;
    logic [31:0] rd;
    int          stalls;
    int          wes;
    int          mis;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   stall_cnt = 0;
  int   we_cnt = 0;
  int   mis_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
      we_cnt    = 0;
      mis_cnt   = 0;
    end else begin
      if (mem_we_o) we_cnt++;
      if (core_misalign_o) mis_cnt++;
      if (core_req_i && core_stall_o) stall_cnt++;
      if (core_req_i && !core_stall_o) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_completion: got 1 expected 0");
        end else begin
          mon_e = q.pop_front();
          if (mon_e.chk_rd) check32({mon_e.name, " rd"}, core_rd_o, mon_e.rd);
          check32({mon_e.name, " stalls"}, 32'(stall_cnt), 32'(mon_e.stalls));
          check32({mon_e.name, " we_cycles"}, 32'(we_cnt), 32'(mon_e.wes));
          check32({mon_e.name, " misalign_cycles"}, 32'(mis_cnt), 32'(mon_e.mis));
        end
        stall_cnt = 0;
        we_cnt    = 0;
        mis_cnt   = 0;
      end
    end
  end

  time t_issue;

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic do_req(input string name, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic chk_rd, input logic [31:0] rd,
                        input int stalls, input int wes, input int mis);
    exp_t e;
    int   n;
    e.name = name; e.chk_rd = chk_rd; e.rd = rd;
    e.stalls = stalls; e.wes = wes; e.mis = mis;
    q.push_back(e);
    t_issue     = $time;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_stall_o && n < 8);
    if (core_stall_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got stall after %0d cycles expected release", name, n);
    end
    @(posedge clk);
    #1;
    core_req_i = 1'b0;
  endtask

  time t_a, t_b, t_c;

  initial begin
    poke(4'd4, 32'h8899AABB);
    poke(4'd8, 32'h0000007F);
    @(negedge clk);
    check32("reset rd", core_rd_o, 32'h0);
    check32("reset misalign", {31'h0, core_misalign_o}, 32'h0);
    check32("reset mem_we", {31'h0, mem_we_o}, 32'h0);
    check32("reset stall", {31'h0, core_stall_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req("LB 0x11",  1'b0, LDST_B,  32'h11,  32'h0, 1'b1, 32'hFFFFFFAA, 1, 0, 0);
    do_req("LBU 0x13", 1'b0, LDST_BU, 32'h13,  32'h0, 1'b1, 32'h00000088, 1, 0, 0);
    do_req("LH 0x12",  1'b0, LDST_H,  32'h12,  32'h0, 1'b1, 32'hFFFF8899, 1, 0, 0);
    do_req("LHU 0x10", 1'b0, LDST_HU, 32'h10,  32'h0, 1'b1, 32'h0000AABB, 1, 0, 0);
    do_req("LB 0x20",  1'b0, LDST_B,  32'h20,  32'h0, 1'b1, 32'h0000007F, 1, 0, 0);
    do_req("LB oor",   1'b0, LDST_B,  32'h100, 32'h0, 1'b1, 32'h00000000, 1, 0, 0);

    do_req("SB 0x12", 1'b1, LDST_B, 32'h12, 32'h123456CC, 1'b0, 32'h0, 2, 1, 0);
    check32("mem after SB", mem[4], 32'h88CCAABB);
    poke(4'd4, 32'h8899AABB);
    do_req("SH 0x10", 1'b1, LDST_H, 32'h10, 32'h0000BEEF, 1'b0, 32'h0, 2, 1, 0);
    check32("mem after SH", mem[4], 32'h8899BEEF);
    do_req("SW 0x10", 1'b1, LDST_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1, 1, 0);
    check32("mem after SW", mem[4], 32'hDEADBEEF);
    do_req("LW 0x10", 1'b0, LDST_W, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1, 0, 0);

`ifdef LSU_MISALIGN_CHECK_EN
    do_req("LW 0x12", 1'b0, LDST_W, 32'h12, 32'h0, 1'b1, 32'h0, 1, 0, 1);
    do_req("SH 0x11", 1'b1, LDST_H, 32'h11, 32'h00001234, 1'b1, 32'h0, 1, 0, 1);
    check32("mem after SH 0x11", mem[4], 32'hDEADBEEF);
    do_req("LD sz011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 1);
    do_req("ST sz100", 1'b1, 3'b100, 32'h10, 32'h00000077, 1'b1, 32'h0, 1, 0, 1);
    check32("mem after ST sz100", mem[4], 32'hDEADBEEF);
    do_req("LB 0x11 post", 1'b0, LDST_B, 32'h11, 32'h0, 1'b1, 32'hFFFFFFBE, 1, 0, 0);
`else
    do_req("LW 0x12", 1'b0, LDST_W, 32'h12, 32'h0, 1'b1, 32'hDEADBEEF, 1, 0, 0);
    do_req("SH 0x11", 1'b1, LDST_H, 32'h11, 32'h00001234, 1'b0, 32'h0, 2, 1, 0);
    check32("mem after SH 0x11", mem[4], 32'hDEAD1234);
    do_req("LD sz011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'hDEAD1234, 1, 0, 0);
    do_req("ST sz100", 1'b1, 3'b100, 32'h10, 32'h00000077, 1'b0, 32'h0, 1, 1, 0);
    check32("mem after ST sz100", mem[4], 32'h00000077);
    do_req("LB 0x11 post", 1'b0, LDST_B, 32'h11, 32'h0, 1'b1, 32'h00000000, 1, 0, 0);
`endif

    // Reset while the SB is in its write cycle.
    do_req("LB 0x20 pre", 1'b0, LDST_B, 32'h20, 32'h0, 1'b1, 32'h0000007F, 1, 0, 0);
    poke(4'd4, 32'h8899AABB);
    core_req_i  = 1'b1;
    core_we_i   = 1'b1;
    core_size_i = LDST_B;
    core_addr_i = 32'h10;
    core_wd_i   = 32'h00000055;
    @(posedge clk);
    #2;
    check32("write state mem_we", {31'h0, mem_we_o}, 32'h1);
    rst_n      = 1'b0;
    core_req_i = 1'b0;
    #1;
    check32("rst in write mem_we", {31'h0, mem_we_o}, 32'h0);
    check32("rst in write rd", core_rd_o, 32'h0);
    check32("rst in write misalign", {31'h0, core_misalign_o}, 32'h0);
    check32("rst in write stall", {31'h0, core_stall_o}, 32'h0);
    @(posedge clk);
    #1;
    check32("mem after rst", mem[4], 32'h8899AABB);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req("SB 0x10 b2b", 1'b1, LDST_B, 32'h10, 32'h000000A5, 1'b0, 32'h0, 2, 1, 0);
    t_a = t_issue;
    do_req("LW 0x10 b2b", 1'b0, LDST_W, 32'h10, 32'h0, 1'b1, 32'h8899AAA5, 1, 0, 0);
    t_b = t_issue;
    do_req("LB 0x11 b2b", 1'b0, LDST_B, 32'h11, 32'h0, 1'b1, 32'hFFFFFFAA, 1, 0, 0);
    t_c = t_issue;
    check32("spacing SB->LW", 32'(t_b - t_a), 32'd30);
    check32("spacing LW->LB", 32'(t_c - t_b), 32'd20);

    repeat (3) @(posedge clk);
    check32("scoreboard empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
